// File: rtl/rs_flag_reader_pkg.sv
// Shared definitions for the rsflipflop flag consumer: FSM encoding and
// the saturation limit helper for the consumed-event counter.
package rs_flag_reader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        PRESENT  = 3'd2,
        CLEAR    = 3'd3,
        WAIT_LOW = 3'd4
    } state_t;

    // Settle counter width; LATENCY is limited to 255.
    localparam int SETTLE_W = 8;

    // All-ones value for a counter of width w (w in 1..32).
    function automatic logic [31:0] sat_max(input int unsigned w);
        logic [31:0] ones;
        ones = '1;
        return (w >= 32) ? ones : (ones >> (32 - w));
    endfunction

endpackage

// File: rtl/rs_flag_settle_cnt.sv
// Loadable down-counter with a zero flag. Loads on 'load', otherwise
// decrements toward zero and holds there.
module rs_flag_settle_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    // Count register: load has priority, then decrement while non-zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (init) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/rs_flag_reader.sv
// Consumer for an rsflipflop event flag: detects the flag, waits a settle
// time, presents it on valid/ready, then clears the flop with a single r
// pulse that never coincides with the writer's s.
module rs_flag_reader
    import rs_flag_reader_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             flag_q,
    input  logic             flag_s,
    output logic             clr_r,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             merge_err,
    output logic             busy
);

    localparam logic [CNT_W-1:0]    CNT_MAX     = CNT_W'(sat_max(CNT_W));
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = (LATENCY > 0) ? SETTLE_W'(LATENCY - 1) : '0;

    state_t state_reg, state_next;
    logic   settle_zero;
    logic   settle_load;

    // Counter is armed on flag detection; with LATENCY=0 SETTLE is skipped.
    assign settle_load = (state_reg == IDLE) && flag_q;

    rs_flag_settle_cnt #(.W(SETTLE_W)) u_settle_cnt (
        .clk      (clk),
        .reset    (reset),
        .init     (init),
        .load     (settle_load),
        .load_val (SETTLE_LOAD),
        .zero     (settle_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else if (init) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the clear is deferred while the writer is setting.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (flag_q) state_next = (LATENCY == 0) ? PRESENT : SETTLE;
            SETTLE:   if (settle_zero) state_next = PRESENT;
            PRESENT:  if (evt_ready) state_next = CLEAR;
            CLEAR:    if (!flag_s) state_next = WAIT_LOW;
            WAIT_LOW: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Saturating count of accepted events.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_count <= '0;
        end else if (init) begin
            evt_count <= '0;
        end else if ((state_reg == PRESENT) && evt_ready && (evt_count != CNT_MAX)) begin
            evt_count <= evt_count + 1'b1;
        end
    end

    // Sticky merge flag: a set while the flag is already owned is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            merge_err <= 1'b0;
        end else if (init) begin
            merge_err <= 1'b0;
        end else if (flag_s && ((state_reg == SETTLE) || (state_reg == PRESENT) ||
                                (state_reg == CLEAR))) begin
            merge_err <= 1'b1;
        end
    end

    // clr_r must see the same-cycle s because the flop samples both on one edge.
    assign clr_r     = (state_reg == CLEAR) && !flag_s;
    assign evt_valid = (state_reg == PRESENT);
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_rs_flag_reader.sv
// Directed bench for rs_flag_reader: two instances (LATENCY=2/CNT_W=8 and
// LATENCY=0/CNT_W=2), each driving a behavioural rsflipflop.
module tb_rs_flag_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init = 1'b0;

    logic       s = 1'b0, q = 1'b0, ready = 1'b1;
    logic       clr, valid, merge, busy;
    logic [7:0] count;

    logic       s0 = 1'b0, q0 = 1'b0, ready0 = 1'b1;
    logic       clr0, valid0, merge0, busy0;
    logic [1:0] count0;

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    rs_flag_reader #(.LATENCY(2), .CNT_W(8)) u_dut (
        .clk(clk), .reset(rst_n), .init(init), .flag_q(q), .flag_s(s),
        .clr_r(clr), .evt_valid(valid), .evt_ready(ready), .evt_count(count),
        .merge_err(merge), .busy(busy)
    );

    rs_flag_reader #(.LATENCY(0), .CNT_W(2)) u_dut0 (
        .clk(clk), .reset(rst_n), .init(init), .flag_q(q0), .flag_s(s0),
        .clr_r(clr0), .evt_valid(valid0), .evt_ready(ready0), .evt_count(count0),
        .merge_err(merge0), .busy(busy0)
    );

    // rsflipflop models (set dominant); not affected by the reader's reset.
    always @(posedge clk) begin
        if (s) q <= 1'b1; else if (clr) q <= 1'b0;
        if (s0) q0 <= 1'b1; else if (clr0) q0 <= 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // clr_r and flag_s must never be high together.
    always @(negedge clk) begin
        if (rst_n) begin
            check("no_clr_with_s", 32'(clr & s), 32'd0);
            check("no_clr_with_s0", 32'(clr0 & s0), 32'd0);
        end
    end

    initial begin
        // Reset state
        tick(); tick();
        check("rst_valid", 32'(valid), 0);
        check("rst_clr", 32'(clr), 0);
        check("rst_count", 32'(count), 0);
        check("rst_merge", 32'(merge), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick();

        // Basic event, LATENCY=2, ready high
        s = 1'b1; tick(); s = 1'b0;             // flop sets here
        tick();                                 // IDLE sees q -> SETTLE
        check("t1_busy", 32'(busy), 1);
        check("t1_valid_early0", 32'(valid), 0);
        tick();
        check("t1_valid_early1", 32'(valid), 0);
        tick();
        check("t1_valid", 32'(valid), 1);
        check("t1_clr_pre", 32'(clr), 0);
        tick();                                 // handshake edge
        check("t1_clr", 32'(clr), 1);
        check("t1_count", 32'(count), 1);
        check("t1_valid_off", 32'(valid), 0);
        tick();
        check("t1_clr_off", 32'(clr), 0);
        check("t1_q_cleared", 32'(q), 0);
        check("t1_busy_wl", 32'(busy), 1);
        tick();
        check("t1_idle", 32'(busy), 0);
        check("t1_merge", 32'(merge), 0);

        // Backpressure: ready low for 20 cycles
        ready = 1'b0;
        s = 1'b1; tick(); s = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 20; i++) begin
            check("t2_hold_valid", 32'(valid), 1);
            check("t2_hold_clr", 32'(clr), 0);
            check("t2_hold_count", 32'(count), 1);
            tick();
        end
        ready = 1'b1;
        pulses = 0;
        tick();
        check("t2_count", 32'(count), 2);
        for (int i = 0; i < 4; i++) begin
            pulses += int'(clr);
            tick();
        end
        check("t2_one_pulse", 32'(pulses), 1);
        check("t2_idle", 32'(busy), 0);

        // Deferred clear while the writer holds s through CLEAR
        s = 1'b1; tick(); s = 1'b0;
        tick(); tick(); tick();                 // now in PRESENT
        s = 1'b1;
        tick();                                 // handshake with s high
        check("t3_merge", 32'(merge), 1);
        check("t3_count", 32'(count), 3);
        check("t3_clr_d0", 32'(clr), 0);
        tick();
        check("t3_clr_d1", 32'(clr), 0);
        tick();
        check("t3_clr_d2", 32'(clr), 0);
        tick();
        s = 1'b0; #1;
        check("t3_clr_4th", 32'(clr), 1);
        tick();
        check("t3_clr_done", 32'(clr), 0);
        check("t3_q_cleared", 32'(q), 0);
        tick();
        check("t3_idle", 32'(busy), 0);

        // Synchronous init clears counter and sticky flag
        init = 1'b1; tick(); init = 1'b0;
        check("init_count", 32'(count), 0);
        check("init_merge", 32'(merge), 0);

        // Async reset while presenting; flag re-consumed after release
        ready = 1'b0;
        s = 1'b1; tick(); s = 1'b0;
        tick(); tick(); tick();
        check("t4_valid_pre", 32'(valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_async_valid", 32'(valid), 0);
        check("t4_async_busy", 32'(busy), 0);
        check("t4_async_clr", 32'(clr), 0);
        tick(); tick();
        check("t4_q_kept", 32'(q), 1);
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        check("t4_rebusy", 32'(busy), 1);
        tick(); tick();
        check("t4_revalid", 32'(valid), 1);
        tick();
        check("t4_recount", 32'(count), 1);
        check("t4_reclr", 32'(clr), 1);
        tick(); tick(); tick(); tick();
        check("t4_count_once", 32'(count), 1);
        check("t4_idle", 32'(busy), 0);

        // LATENCY=0, CNT_W=2: saturation over five events
        for (int i = 0; i < 5; i++) begin
            s0 = 1'b1; tick(); s0 = 1'b0;
            tick();                             // IDLE sees q0 -> PRESENT
            check("t5_valid", 32'(valid0), 1);
            tick();
            check("t5_count", 32'(count0), (i < 3) ? i + 1 : 3);
            check("t5_clr", 32'(clr0), 1);
            tick(); tick();
            check("t5_idle", 32'(busy0), 0);
        end
        check("t5_merge", 32'(merge0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_flag_reader.md
Name: rs_flag_reader

Overview:
- Consumer-side companion to the rsflipflop event flag.
- A writer raises the flag through the flop's s input. This block detects the flag and waits a settle time.
- It then presents the event downstream on a valid/ready handshake. After acceptance it drives the flop's r input for exactly one cycle to clear the flag.
- It guarantees r is never asserted in the same cycle as the writer's s, counts consumed events, and flags merged (lost) sets.

Parameters:
- LATENCY, 2, settle cycles between flag detection and evt_valid (0 allowed, max 255).
- CNT_W, 8, width of the saturating consumed-event counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  synchronous re-initialise, same effect as reset.
- flag_q  in  1  q of the rsflipflop being read.
- flag_s  in  1  writer's s request to the same flop, observed for collision avoidance.
- clr_r  out  1  to the rsflipflop r input; single-cycle clear pulse.
- evt_valid  out  1  event available downstream.
- evt_ready  in  1  downstream accepts the event.
- evt_count  out  CNT_W  consumed events, saturating.
- merge_err  out  1  sticky: a set arrived while an event was already pending.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async) or init=1 (sync, priority over all else):
  - state=IDLE, clr_r=0, evt_valid=0, evt_count=0, merge_err=0, busy=0.
- FSM states: IDLE, SETTLE, PRESENT, CLEAR, WAIT_LOW.
- IDLE:
  - flag_q=1 at edge k: go to SETTLE (LATENCY>0) or PRESENT (LATENCY=0).
  - flag_q=0: stay in IDLE.
- SETTLE:
  - Down-counter loaded with LATENCY-1 on entry; go to PRESENT when it reaches 0.
  - evt_valid is therefore high from edge k+LATENCY (LATENCY=0: from edge k).
  - flag_q is not re-checked in SETTLE; the flop is only cleared by this block.
- PRESENT:
  - evt_valid=1 (registered, Moore).
  - Hold until evt_valid & evt_ready at edge m, then go to CLEAR.
  - evt_count increments at edge m, saturating at 2^CNT_W-1 (no wrap).
- CLEAR:
  - clr_r = (state==CLEAR) & ~flag_s. This is the only combinational path through the block, and it is required because the flop samples s and r on the same edge.
  - flag_s=0: clr_r pulses this cycle; go to WAIT_LOW.
  - flag_s=1: clr_r=0; stay in CLEAR (deferred clear, retried each cycle).
- WAIT_LOW:
  - One cycle, lets the flop's q update; then go to IDLE unconditionally.
  - A writer set that lands in WAIT_LOW is seen as a new event from IDLE.
- merge_err:
  - Set when flag_s=1 in SETTLE, PRESENT or CLEAR, since the flag is already set and that event is merged.
  - Cleared only by reset/init.
- Throughput: max one event per LATENCY+4 cycles with evt_ready tied high.
- Invariant: clr_r and flag_s are never both 1. The bench asserts this every cycle.
- Reset mid-operation: everything returns to IDLE, the flag in the flop is left as-is, and it is re-consumed after reset release.

Decomposition:
- Shared package: FSM state encoding (3-bit localparams IDLE..WAIT_LOW) and a CNT_W saturating-max helper constant.
- Natural sub-module: rs_flag_settle_cnt, the loadable down-counter with a zero flag, reusable by other flag consumers.
- The rest is a single flat module.

Test Plan:
- LATENCY=2, evt_ready=1: flag_q rises before edge 10 -> evt_valid high after edge 12; clr_r=1 in the cycle after handshake edge 13; evt_count=1; busy low after edge 15.
- evt_ready held 0 for 20 cycles: evt_valid stays 1, clr_r stays 0 and evt_count stays 0 throughout; ready=1 -> single clr_r pulse, count=1.
- flag_s=1 during CLEAR for 3 cycles: clr_r=0 for those 3 cycles, pulses on the 4th; merge_err=1; the clr_r&flag_s assertion never fires.
- evt_count with CNT_W=2: 5 events -> evt_count reads 1,2,3,3,3.
- LATENCY=0: flag_q sampled at edge k -> evt_valid after edge k.
- reset asserted in PRESENT: outputs are 0 immediately (async); after release, with flag_q still 1, the event is re-presented and counted once.
